// File: rtl/ysyx_22050019_axi_pkg.sv
// Shared AXI-lite style definitions for the cache refill path:
// response codes, slave state encoding and the default memory window base.
package ysyx_22050019_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } slv_state_e;

endpackage

// File: rtl/ysyx_22050019_rsp_mem.sv
// Word array behind the read responder: one synchronous write port and one
// combinational read port. Contents are never reset.
module ysyx_22050019_rsp_mem #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 1024,
  parameter int IDX_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [IDX_WIDTH-1:0]  wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [IDX_WIDTH-1:0]  rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Preload write; a read sampled on the same edge still sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/ysyx_22050019_axi_r_slave.sv
// Single-beat read responder standing in for main memory on the icache
// refill path. Accepts one AR at a time, waits LATENCY cycles, returns the
// addressed word (or DECERR outside the window) and holds it until r_ready_i.
module ysyx_22050019_axi_r_slave
  import ysyx_22050019_axi_pkg::*;
#(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(DEFAULT_BASE_ADDR),
  parameter int                    DEPTH      = 1024,
  parameter int                    IDX_WIDTH  = 10,
  parameter int                    LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ar_valid_i,
  output logic                  ar_ready_o,
  input  logic [ADDR_WIDTH-1:0] ar_addr_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [1:0]            r_resp_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  input  logic                  wr_en_i,
  input  logic [IDX_WIDTH-1:0]  wr_idx_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic [31:0]           rd_count_o
);

  slv_state_e            state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic [IDX_WIDTH-1:0]  idx_q, idx_nxt;
  logic                  hit_q, hit_nxt;

  logic                  ar_ready_nxt;
  logic                  r_valid_nxt;
  logic [1:0]            r_resp_nxt;
  logic [DATA_WIDTH-1:0] r_data_nxt;
  logic [31:0]           rd_count_nxt;

  logic [ADDR_WIDTH-1:0] off;
  logic                  dec_hit;
  logic [IDX_WIDTH-1:0]  dec_idx;
  logic                  ar_hs, r_hs;
  logic [IDX_WIDTH-1:0]  rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  assign off     = ar_addr_i - BASE_ADDR;
  assign dec_hit = (ar_addr_i >= BASE_ADDR) && ((off >> 3) < ADDR_WIDTH'(DEPTH));
  assign dec_idx = off[IDX_WIDTH+2:3];

  assign ar_hs = ar_valid_i & ar_ready_o;
  assign r_hs  = r_valid_o & r_ready_i;

  // In IDLE the zero-latency path samples straight from the incoming address.
  assign rd_idx = (state == S_IDLE) ? dec_idx : idx_q;

  ysyx_22050019_rsp_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en_i),
    .wr_idx  (wr_idx_i),
    .wr_data (wr_data_i),
    .rd_idx  (rd_idx),
    .rd_data (rd_word)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; an unknown encoding falls back to IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (ar_hs) begin
          state_nxt = (LATENCY == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt <= 4'd1) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (r_hs) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, the latency counter and the latched request.
  always_comb begin
    ar_ready_nxt = ar_ready_o;
    r_valid_nxt  = r_valid_o;
    r_resp_nxt   = r_resp_o;
    r_data_nxt   = r_data_o;
    rd_count_nxt = rd_count_o;
    cnt_nxt      = cnt;
    idx_nxt      = idx_q;
    hit_nxt      = hit_q;
    unique case (state)
      S_IDLE: begin
        if (ar_hs) begin
          ar_ready_nxt = 1'b0;
          cnt_nxt      = 4'(LATENCY);
          idx_nxt      = dec_idx;
          hit_nxt      = dec_hit;
          if (LATENCY == 0) begin
            r_valid_nxt = 1'b1;
            r_data_nxt  = dec_hit ? rd_word : '0;
            r_resp_nxt  = dec_hit ? RESP_OKAY : RESP_DECERR;
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          r_valid_nxt = 1'b1;
          r_data_nxt  = hit_q ? rd_word : '0;
          r_resp_nxt  = hit_q ? RESP_OKAY : RESP_DECERR;
        end
      end
      S_RESP: begin
        if (r_hs) begin
          r_valid_nxt  = 1'b0;
          r_data_nxt   = '0;
          r_resp_nxt   = RESP_OKAY;
          ar_ready_nxt = 1'b1;
          rd_count_nxt = rd_count_o + 32'd1;
        end
      end
      default: begin
        ar_ready_nxt = 1'b1;
        r_valid_nxt  = 1'b0;
        r_data_nxt   = '0;
        r_resp_nxt   = RESP_OKAY;
        cnt_nxt      = 4'd0;
      end
    endcase
  end

  // Output and counter registers; reset drops any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_ready_o <= 1'b1;
      r_valid_o  <= 1'b0;
      r_resp_o   <= RESP_OKAY;
      r_data_o   <= '0;
      rd_count_o <= 32'd0;
      cnt        <= 4'd0;
    end else begin
      ar_ready_o <= ar_ready_nxt;
      r_valid_o  <= r_valid_nxt;
      r_resp_o   <= r_resp_nxt;
      r_data_o   <= r_data_nxt;
      rd_count_o <= rd_count_nxt;
      cnt        <= cnt_nxt;
    end
  end

  // Latched request index and decode result; only meaningful while a read is pending.
  always_ff @(posedge clk) begin
    idx_q <= idx_nxt;
    hit_q <= hit_nxt;
  end

endmodule
